fifo_bist_ctrl: RTL and testbench

- Single-clock BIST sequencer for the 10-deep Johnson-pointer FIFO.
- Drives the FIFO write/read increments and write data through four data patterns (fill-to-full, then drain-to-empty per pattern).
- Checks the full/empty flags and every read word; latches the first failure.
- Sits between the test access logic (START/DONE/FAIL) and the FIFO's W_INC/R_INC/W_DATA/R_DATA/W_FULL/R_EMPTY ports.

---
 rtl/fifo_bist_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_fifo_bist_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bist_ctrl.sv
// BIST sequencer for a DEPTH-word FIFO: four fill/drain passes with flag and
// read-data checks; the first failure is latched and the run stops at once.
module fifo_bist_ctrl #(
    parameter int DEPTH    = 10,
    parameter int WIDTH    = 8,
    parameter int FLAG_LAT = 2,
    parameter int RD_LAT   = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic                     W_FULL,
    input  logic                     R_EMPTY,
    input  logic [WIDTH-1:0]         R_DATA,
    output logic                     W_INC,
    output logic [WIDTH-1:0]         W_DATA,
    output logic                     R_INC,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     FAIL,
    output logic [2:0]               FAIL_CODE,
    output logic [1:0]               FAIL_PASS,
    output logic [$clog2(DEPTH)-1:0] FAIL_IDX,
    output logic [2:0]               DBG_STATE
);
    localparam int AW        = $clog2(DEPTH);
    localparam int RWAIT_LEN = (FLAG_LAT > RD_LAT) ? FLAG_LAT : RD_LAT;
    localparam int CW        = $clog2(RWAIT_LEN + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Level handshake: START is sampled only in IDLE/DONE; BUSY covers the run,
    // DONE is held until START drops, and IDLE is needed before the next run.
    typedef enum logic [2:0] {
        S_IDLE, S_PRECHK, S_WRITE, S_WWAIT, S_READ, S_RWAIT, S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        pass;
    logic [AW-1:0]     idx;
    logic [CW-1:0]     wait_cnt;

    logic              chk_fail;
    logic [2:0]        chk_code;
    logic [AW-1:0]     chk_idx;

    logic              cur_v;
    logic [WIDTH-1:0]  cur_exp;
    logic [AW-1:0]     cur_idx;
    logic              out_v;
    logic [WIDTH-1:0]  out_exp;
    logic [AW-1:0]     out_idx;

    function automatic logic [WIDTH-1:0] pattern(input logic [1:0] p, input logic [AW-1:0] i);
        logic [WIDTH-1:0] d;
        d = '0;
        case (p)
            2'd0:    for (int b = 0; b < WIDTH; b++) d[b] = (b % 2 == 0);
            2'd1:    for (int b = 0; b < WIDTH; b++) d[b] = (b % 2 == 1);
            2'd2:    d = WIDTH'(i);
            default: d = ~WIDTH'(i);
        endcase
        return d;
    endfunction

    assign DBG_STATE = state;

    // R_INC is high exactly while in READ, so each READ cycle launches one compare.
    assign cur_v   = (state == S_READ);
    assign cur_exp = pattern(pass, idx);
    assign cur_idx = idx;

    generate
        if (RD_LAT == 0) begin : g_direct
            assign out_v   = cur_v;
            assign out_exp = cur_exp;
            assign out_idx = cur_idx;
        end else begin : g_pipe
            logic [RD_LAT-1:0] pipe_v;
            logic [WIDTH-1:0]  pipe_exp [RD_LAT];
            logic [AW-1:0]     pipe_idx [RD_LAT];

            always_ff @(posedge CLK) begin
                if (!RST || chk_fail) begin
                    pipe_v <= '0;
                end else begin
                    pipe_v[0] <= cur_v;
                    for (int k = 1; k < RD_LAT; k++) pipe_v[k] <= pipe_v[k-1];
                end
                pipe_exp[0] <= cur_exp;
                pipe_idx[0] <= cur_idx;
                for (int k = 1; k < RD_LAT; k++) begin
                    pipe_exp[k] <= pipe_exp[k-1];
                    pipe_idx[k] <= pipe_idx[k-1];
                end
            end

            assign out_v   = pipe_v[RD_LAT-1];
            assign out_exp = pipe_exp[RD_LAT-1];
            assign out_idx = pipe_idx[RD_LAT-1];
        end
    endgenerate

    // A data mismatch outranks a flag failure landing on the same cycle.
    always_comb begin
        chk_fail = 1'b0;
        chk_code = 3'd0;
        chk_idx  = '0;
        if (out_v && (out_exp != R_DATA)) begin
            chk_fail = 1'b1;
            chk_code = 3'd3;
            chk_idx  = out_idx;
        end else begin
            case (state)
                S_PRECHK: if (!R_EMPTY || W_FULL) begin
                    chk_fail = 1'b1;
                    chk_code = 3'd1;
                end
                S_WWAIT: if ((wait_cnt == '0) && (!W_FULL || R_EMPTY)) begin
                    chk_fail = 1'b1;
                    chk_code = 3'd2;
                end
                S_RWAIT: if ((wait_cnt == '0) && (!R_EMPTY || W_FULL)) begin
                    chk_fail = 1'b1;
                    chk_code = 3'd4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= S_IDLE;
            pass      <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
            W_INC     <= 1'b0;
            W_DATA    <= '0;
            R_INC     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_CODE <= '0;
            FAIL_PASS <= '0;
            FAIL_IDX  <= '0;
        end else if (chk_fail) begin
            state     <= S_DONE;
            W_INC     <= 1'b0;
            W_DATA    <= '0;
            R_INC     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            FAIL      <= 1'b1;
            FAIL_CODE <= chk_code;
            FAIL_PASS <= pass;
            FAIL_IDX  <= chk_idx;
        end else begin
            case (state)
                S_IDLE: if (START) begin
                    state     <= S_PRECHK;
                    BUSY      <= 1'b1;
                    pass      <= '0;
                    idx       <= '0;
                    FAIL      <= 1'b0;
                    FAIL_CODE <= '0;
                    FAIL_PASS <= '0;
                    FAIL_IDX  <= '0;
                end
                S_PRECHK: begin
                    state  <= S_WRITE;
                    idx    <= '0;
                    W_INC  <= 1'b1;
                    W_DATA <= pattern(pass, '0);
                end
                S_WRITE: if (idx == LAST) begin
                    state    <= S_WWAIT;
                    W_INC    <= 1'b0;
                    W_DATA   <= '0;
                    wait_cnt <= CW'(FLAG_LAT - 1);
                end else begin
                    idx    <= idx + 1'b1;
                    W_DATA <= pattern(pass, idx + 1'b1);
                end
                S_WWAIT: if (wait_cnt == '0) begin
                    state <= S_READ;
                    idx   <= '0;
                    R_INC <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
                S_READ: if (idx == LAST) begin
                    state    <= S_RWAIT;
                    R_INC    <= 1'b0;
                    wait_cnt <= CW'(RWAIT_LEN - 1);
                end else begin
                    idx <= idx + 1'b1;
                end
                S_RWAIT: if (wait_cnt == '0) begin
                    if (pass == 2'd3) begin
                        state <= S_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        pass   <= pass + 2'd1;
                        state  <= S_WRITE;
                        idx    <= '0;
                        W_INC  <= 1'b1;
                        W_DATA <= pattern(pass + 2'd1, '0);
                    end
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
                S_DONE: if (!START) begin
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_bist_ctrl.sv
// Bench for fifo_bist_ctrl: queue-based FIFO model with fault knobs, expected
// outcomes computed from the pattern/timing rules, write-data scoreboard.
`timescale 1ns/1ps
module tb_fifo_bist_ctrl;
    localparam int DEPTH     = 10;
    localparam int WIDTH     = 8;
    localparam int FLAG_LAT  = 2;
    localparam int RD_LAT    = 1;
    localparam int RWAIT_LEN = (FLAG_LAT > RD_LAT) ? FLAG_LAT : RD_LAT;
    localparam int PASS_CYC  = 2 * DEPTH + FLAG_LAT + RWAIT_LEN;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             w_full, r_empty;
    logic [WIDTH-1:0] r_data;
    logic             w_inc, r_inc, busy, done, fail;
    logic [WIDTH-1:0] w_data;
    logic [2:0]       fail_code;
    logic [1:0]       fail_pass;
    logic [3:0]       fail_idx;
    logic [2:0]       dbg_state;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_bist_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FLAG_LAT(FLAG_LAT), .RD_LAT(RD_LAT)) dut (
        .CLK(clk), .RST(rst), .START(start),
        .W_FULL(w_full), .R_EMPTY(r_empty), .R_DATA(r_data),
        .W_INC(w_inc), .W_DATA(w_data), .R_INC(r_inc),
        .BUSY(busy), .DONE(done), .FAIL(fail),
        .FAIL_CODE(fail_code), .FAIL_PASS(fail_pass), .FAIL_IDX(fail_idx),
        .DBG_STATE(dbg_state)
    );

    // Fault knobs
    bit force_full = 0;
    bit gap_en = 0;
    int gap_pass = 0;
    bit est_en = 0;
    int est_pass = 0;
    bit stuck_en = 0;
    int stuck_bit = 0;
    bit stuck_val = 0;
    int wr_base = 0;
    int rd_base = 0;

    // Monitor counters
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, wdata_cnt = 0, after_fail_cnt = 0;
    int ovf_cnt = 0, udf_cnt = 0;
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] exp_q[$];

    // FIFO model: data queue with flags delayed FLAG_LAT cycles and 1-cycle read data.
    logic [WIDTH-1:0] mem_q[$];
    logic [WIDTH-1:0] rd_reg;
    logic [1:0]       full_sr, empty_sr;

    always @(posedge clk) begin : fifo_model
        int n;
        if (!rst) begin
            mem_q.delete();
            full_sr  <= 2'b00;
            empty_sr <= 2'b11;
            rd_reg   <= '0;
        end else begin
            if (w_inc) begin
                if (mem_q.size() >= DEPTH) ovf_cnt <= ovf_cnt + 1;
                else mem_q.push_back(w_data);
            end
            if (r_inc) begin
                if (mem_q.size() == 0) udf_cnt <= udf_cnt + 1;
                else rd_reg <= mem_q.pop_front();
            end
            n = mem_q.size();
            full_sr  <= {full_sr[0], n == DEPTH};
            empty_sr <= {empty_sr[0], n == 0};
        end
    end

    assign w_full = force_full | (full_sr[1] & ~(gap_en
                    && ((wr_cnt - wr_base) > DEPTH * gap_pass)
                    && ((wr_cnt - wr_base) <= DEPTH * gap_pass + DEPTH)));
    assign r_empty = empty_sr[1] & ~(est_en && ((rd_cnt - rd_base) >= DEPTH * (est_pass + 1)));
    assign r_data = !stuck_en ? rd_reg :
                    stuck_val ? (rd_reg | (8'h01 << stuck_bit)) : (rd_reg & ~(8'h01 << stuck_bit));

    always @(negedge clk) begin
        if (w_inc) begin
            wr_cnt <= wr_cnt + 1;
            got_q.push_back(w_data);
        end
        if (r_inc) rd_cnt <= rd_cnt + 1;
        if (w_inc && r_inc) both_cnt <= both_cnt + 1;
        if (!w_inc && (w_data != '0)) wdata_cnt <= wdata_cnt + 1;
        if (fail && (w_inc || r_inc)) after_fail_cnt <= after_fail_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [WIDTH-1:0] pat(input int p, input int i);
        case (p)
            0:       return 8'h55;
            1:       return 8'hAA;
            2:       return 8'(i);
            default: return ~8'(i);
        endcase
    endfunction

    // mode: 0 good, 1 read bit stuck, 2 full missing on pass k, 3 empty stuck after pass k, 4 full at precheck
    task automatic expect_for(input int mode, input int k, input int b, input int v,
                              output int e_code, output int e_pass, output int e_idx,
                              output int e_cyc, output int e_w, output int e_r);
        logic [WIDTH-1:0] d, f;
        bit found;
        e_code = 0; e_pass = 0; e_idx = 0;
        e_cyc = 2 + 4 * PASS_CYC; e_w = 4 * DEPTH; e_r = 4 * DEPTH;
        found = 0;
        case (mode)
            1: for (int p = 0; p < 4; p++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    d = pat(p, i);
                    f = v ? (d | (8'h01 << b)) : (d & ~(8'h01 << b));
                    if (!found && (f != d)) begin
                        found = 1;
                        e_code = 3; e_pass = p; e_idx = i;
                        e_cyc = 2 + p * PASS_CYC + DEPTH + FLAG_LAT + i + 1 + RD_LAT;
                        e_w = DEPTH * (p + 1);
                        e_r = DEPTH * p + ((i + 1 + RD_LAT < DEPTH) ? i + 1 + RD_LAT : DEPTH);
                    end
                end
            end
            2: begin
                e_code = 2; e_pass = k;
                e_cyc = 2 + k * PASS_CYC + DEPTH + FLAG_LAT;
                e_w = DEPTH * (k + 1); e_r = DEPTH * k;
            end
            3: begin
                e_code = 4; e_pass = k;
                e_cyc = 2 + (k + 1) * PASS_CYC;
                e_w = DEPTH * (k + 1); e_r = DEPTH * (k + 1);
            end
            4: begin
                e_code = 1; e_cyc = 2; e_w = 0; e_r = 0;
            end
            default: ;
        endcase
    endtask

    task automatic set_knobs(input int mode, input int k, input int b, input int v);
        force_full = (mode == 4);
        gap_en = (mode == 2);  gap_pass = k;
        est_en = (mode == 3);  est_pass = k;
        stuck_en = (mode == 1); stuck_bit = b; stuck_val = v[0];
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_code"}, fail_code, 0);
        check({tag, "_pass"}, fail_pass, 0);
        check({tag, "_idx"}, fail_idx, 0);
        check({tag, "_winc"}, w_inc, 0);
        check({tag, "_rinc"}, r_inc, 0);
        check({tag, "_wdata"}, w_data, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Called at a negedge with the DUT in IDLE; counts rising edges until DONE.
    task automatic run_to_done(input bit rand_start, output int cyc);
        cyc = 0;
        start = 1'b1;
        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) break;
            if (rand_start) start = 1'($urandom_range(0, 1));
        end
        start = 1'b1;
    endtask

    task automatic run_case(input string tag, input int mode, input int k, input int b,
                            input int v, input bit rand_start);
        int e_code, e_pass, e_idx, e_cyc, e_w, e_r;
        int cyc, gb, w0, r0, both0, wd0, af0, ovf0, udf0, h;
        expect_for(mode, k, b, v, e_code, e_pass, e_idx, e_cyc, e_w, e_r);
        set_knobs(mode, k, b, v);
        w0 = wr_cnt; r0 = rd_cnt; both0 = both_cnt; wd0 = wdata_cnt;
        af0 = after_fail_cnt; ovf0 = ovf_cnt; udf0 = udf_cnt;
        wr_base = wr_cnt; rd_base = rd_cnt;
        gb = got_q.size();
        run_to_done(rand_start, cyc);
        check({tag, "_done"}, done, 1);
        check({tag, "_cycles"}, cyc, e_cyc);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fail"}, fail, (e_code != 0));
        check({tag, "_code"}, fail_code, e_code);
        check({tag, "_pass"}, fail_pass, e_pass);
        check({tag, "_idx"}, fail_idx, e_idx);
        check({tag, "_nwrite"}, wr_cnt - w0, e_w);
        check({tag, "_nread"}, rd_cnt - r0, e_r);
        check({tag, "_both_inc"}, both_cnt - both0, 0);
        check({tag, "_wdata_idle"}, wdata_cnt - wd0, 0);
        check({tag, "_inc_after_fail"}, after_fail_cnt - af0, 0);
        check({tag, "_overflow"}, ovf_cnt - ovf0, 0);
        check({tag, "_underflow"}, udf_cnt - udf0, 0);
        exp_q.delete();
        for (int j = 0; j < e_w; j++) exp_q.push_back(pat(j / DEPTH, j % DEPTH));
        for (int j = gb; j < got_q.size(); j++) begin
            if (exp_q.size() > 0) check({tag, "_wdata"}, got_q[j], exp_q.pop_front());
        end
        h = $urandom_range(1, 3);
        repeat (h) @(negedge clk);
        check({tag, "_done_hold"}, done, 1);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_release"}, done, 0);
        check({tag, "_fail_sticky"}, fail, (e_code != 0));
        check({tag, "_code_sticky"}, fail_code, e_code);
    endtask

    initial begin
        int r, mode;
        set_knobs(0, 0, 0, 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_idle("reset");

        run_case("good", 0, 0, 0, 0, 0);
        do_reset(); run_case("stuck3", 1, 0, 3, 1, 0);
        do_reset(); run_case("nofull", 2, 0, 0, 0, 0);
        do_reset(); run_case("noempty", 3, 1, 0, 0, 0);
        do_reset(); run_case("prechk", 4, 0, 0, 0, 0);
        run_case("rerun", 0, 0, 0, 0, 0);

        // Reset in the middle of the pass-2 write burst with START held high.
        do_reset();
        set_knobs(0, 0, 0, 0);
        start = 1'b1;
        r = $urandom_range(2 * PASS_CYC + 3, 2 * PASS_CYC + DEPTH);
        repeat (r) @(negedge clk);
        check("midrst_in_write", w_inc, 1);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        rst = 1'b1;
        run_case("after_rst", 0, 0, 0, 0, 0);

        for (int n = 0; n < 8; n++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            mode = $urandom_range(0, 3);
            run_case("rand", mode, $urandom_range(0, 3), $urandom_range(0, 7),
                     $urandom_range(0, 1), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
